// File: rtl/fifo_input_arbiter.sv
// Round-robin arbiter sharing the write port of the shift-register FIFO between
// producers A and B, with occupancy tracking, full backpressure and sticky underflow.
module fifo_input_arbiter #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_req,
  input  logic [WIDTH-1:0]    a_data,
  output logic                a_ack,
  input  logic                b_req,
  input  logic [WIDTH-1:0]    b_data,
  output logic                b_ack,
  output logic [WIDTH-1:0]    fifo_d_in,
  output logic                fifo_d_in_strobe,
  input  logic                fifo_pop,
  output logic [CNT_BITS-1:0] count,
  output logic                full,
  output logic                empty,
  output logic                underflow
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PUSH = 1'b1
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1'b1);
  localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(DEPTH);

  state_t              state_r;
  state_t              next_state_s;
  logic                last_grant_b_r;
  logic                grant_s;
  logic                pick_a_s;
  logic                pop_v_s;
  logic                underflow_set_s;
  logic [WIDTH-1:0]    data_s;
  logic [CNT_BITS-1:0] count_next_s;
  logic [CNT_BITS-1:0] count_r;
  logic [WIDTH-1:0]    d_in_r;
  logic                strobe_r;
  logic                a_ack_r;
  logic                b_ack_r;
  logic                underflow_r;

  assign full             = (count_r == CNT_MAX);
  assign empty            = (count_r == CNT_ZERO);
  assign count            = count_r;
  assign fifo_d_in        = d_in_r;
  assign fifo_d_in_strobe = strobe_r;
  assign a_ack            = a_ack_r;
  assign b_ack            = b_ack_r;
  assign underflow        = underflow_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state: a grant always costs exactly one PUSH cycle
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          next_state_s = PUSH;
        end else begin
          next_state_s = IDLE;
        end
      end
      PUSH:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Grant decision and occupancy update; full is judged on the pre-edge count
  always_comb begin
    grant_s         = (state_r == IDLE) && !full && (a_req || b_req);
    pick_a_s        = a_req && (!b_req || last_grant_b_r);
    pop_v_s         = fifo_pop && !empty;
    underflow_set_s = fifo_pop && empty;
    data_s          = pick_a_s ? a_data : b_data;
    if (grant_s && !pop_v_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (!grant_s && pop_v_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Registered outputs, round-robin pointer and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      d_in_r         <= '0;
      strobe_r       <= 1'b0;
      a_ack_r        <= 1'b0;
      b_ack_r        <= 1'b0;
      count_r        <= '0;
      underflow_r    <= 1'b0;
      last_grant_b_r <= 1'b1;
    end else begin
      strobe_r <= grant_s;
      a_ack_r  <= grant_s && pick_a_s;
      b_ack_r  <= grant_s && !pick_a_s;
      count_r  <= count_next_s;
      if (grant_s) begin
        d_in_r         <= data_s;
        last_grant_b_r <= !pick_a_s;
      end
      if (underflow_set_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_input_arbiter.sv
// Bench for fifo_input_arbiter: directed scenarios with literal expectations,
// then protocol-respecting random traffic checked every cycle against a model.
module tb_fifo_input_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CNT_BITS = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                a_req, b_req, fifo_pop;
  logic [WIDTH-1:0]    a_data, b_data;
  logic                a_ack, b_ack, fifo_d_in_strobe, full, empty, underflow;
  logic [WIDTH-1:0]    fifo_d_in;
  logic [CNT_BITS-1:0] count;

  int n_cmp = 0;
  int n_err = 0;

  fifo_input_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_data(b_data), .b_ack(b_ack),
    .fifo_d_in(fifo_d_in), .fifo_d_in_strobe(fifo_d_in_strobe),
    .fifo_pop(fifo_pop), .count(count), .full(full), .empty(empty),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a push is allowed at an edge unless one happened at the previous edge.
  int             m_cnt;
  bit             m_unf, m_last_b, m_recent, m_strobe, m_aa, m_ba, model_valid;
  logic [7:0]     m_d;
  bit             go, pick_a;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0; m_unf = 0; m_last_b = 1; m_recent = 0;
      m_strobe = 0; m_aa = 0; m_ba = 0; m_d = 8'h00;
      model_valid = 1;
    end else if (model_valid) begin
      go     = !m_recent && (m_cnt < DEPTH) && (a_req || b_req);
      pick_a = a_req && (!b_req || m_last_b);
      if (fifo_pop && m_cnt == 0) m_unf = 1;
      if (go) begin
        m_d      = pick_a ? a_data : b_data;
        m_last_b = !pick_a;
      end
      m_cnt    = m_cnt + (go ? 1 : 0) - ((fifo_pop && m_cnt > 0) ? 1 : 0);
      m_strobe = go;
      m_aa     = go && pick_a;
      m_ba     = go && !pick_a;
      m_recent = go;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("m_strobe", fifo_d_in_strobe, m_strobe);
      check("m_a_ack", a_ack, m_aa);
      check("m_b_ack", b_ack, m_ba);
      check("m_d_in", fifo_d_in, m_d);
      check("m_count", count, m_cnt);
      check("m_full", full, m_cnt == DEPTH);
      check("m_empty", empty, m_cnt == 0);
      check("m_underflow", underflow, m_unf);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    model_valid = 0;
    reset = 1; a_req = 1; a_data = 8'hAA; b_req = 0; b_data = 8'h00; fifo_pop = 0;
    step(); step();
    reset = 0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_strobe", fifo_d_in_strobe, 0);
    step();
    check("single_strobe", fifo_d_in_strobe, 1);
    check("single_a_ack", a_ack, 1);
    check("single_d_in", fifo_d_in, 8'hAA);
    check("single_count", count, 1);
    step();
    check("no_double_strobe", fifo_d_in_strobe, 0);
    check("no_double_ack", a_ack, 0);
    check("no_double_count", count, 1);
    a_req = 0;

    // round robin from a clean reset
    reset = 1; step(); reset = 0;
    a_req = 1; b_req = 1; a_data = 8'h11; b_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_strobe", fifo_d_in_strobe, 1);
      check("rr_data", fifo_d_in, (i % 2 == 0) ? 8'h11 : 8'h22);
      check("rr_a_ack", a_ack, (i % 2 == 0));
      step();
      check("rr_gap", fifo_d_in_strobe, 0);
    end
    check("rr_count", count, 4);

    // fill up, then backpressure
    b_req = 0; a_data = 8'h33;
    for (int i = 0; i < 8; i++) step();
    check("fill_count", count, 8);
    check("fill_full", full, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_strobe", fifo_d_in_strobe, 0);
      check("bp_ack", a_ack, 0);
    end
    fifo_pop = 1; step();
    check("pop_count", count, 7);
    check("pop_full", full, 0);
    check("pop_no_push", fifo_d_in_strobe, 0);
    fifo_pop = 0; step();
    check("refill_strobe", fifo_d_in_strobe, 1);
    check("refill_count", count, 8);
    a_req = 0; step();

    // drain to 3, then push and pop together
    fifo_pop = 1;
    for (int i = 0; i < 5; i++) step();
    check("drain_count", count, 3);
    a_req = 1; a_data = 8'h44; step();
    check("pushpop_strobe", fifo_d_in_strobe, 1);
    check("pushpop_count", count, 3);
    a_req = 0; fifo_pop = 0;

    // underflow is sticky until reset
    reset = 1; step(); reset = 0;
    fifo_pop = 1; step();
    check("unf_count", count, 0);
    check("unf_set", underflow, 1);
    fifo_pop = 0; step(); step();
    check("unf_sticky", underflow, 1);

    // reset during the PUSH cycle
    a_req = 1; a_data = 8'h55; step();
    check("midpush_strobe", fifo_d_in_strobe, 1);
    reset = 1; step();
    check("midrst_strobe", fifo_d_in_strobe, 0);
    check("midrst_ack", a_ack, 0);
    check("midrst_count", count, 0);
    check("midrst_unf", underflow, 0);
    reset = 0; b_req = 1; a_data = 8'h66; b_data = 8'h77; step();
    check("midrst_first_a", a_ack, 1);
    check("midrst_first_d", fifo_d_in, 8'h66);
    a_req = 0; b_req = 0; step();

    // random producers obeying the hold-until-ack protocol
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (m_aa || !a_req) begin
        a_req = $urandom_range(0, 1);
        a_data = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        a_req = 0;
      end
      if (m_ba || !b_req) begin
        b_req = $urandom_range(0, 1);
        b_data = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        b_req = 0;
      end
      fifo_pop = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
